// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared settings for the instruction-fetch stage: datapath width, prefetch
// FIFO depth, reset PC, the instruction presented when nothing is valid, and
// the credit check that decides whether another fetch may be issued.
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

  localparam int WORD_WIDTH       = 32;
  localparam int FETCH_FIFO_DEPTH = 4;

  localparam logic [WORD_WIDTH-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [WORD_WIDTH-1:0] INSTR_NOP = 32'h0000_0000;

  // A new request may go out only if every slot it could eventually need is
  // free: entries already buffered plus responses still owed, minus the entry
  // leaving this cycle, must stay below the FIFO depth.
  function automatic logic fetch_credit_ok(
    input int unsigned count,
    input int unsigned outstanding,
    input int unsigned deq,
    input int unsigned depth
  );
    return ((count + outstanding - deq) < depth);
  endfunction

endpackage

// File: rtl/if_fetch_stage_fetch_fifo.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_fetch_fifo
// Synchronous FIFO whose head entry is held in a register, so head_valid /
// head_data are flop outputs that can drive the IF/ID boundary directly.
//
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   push, push_data   write one entry (ignored when full and not popping)
//   pop               remove the head entry
//   flush             drop every entry (wins over push/pop)
//   hold              keep head_valid/head_data unchanged this cycle
//   count, full, empty occupancy status
//   head_valid        head register holds a real entry
//   head_data         head entry, all zeros when head_valid = 0
// -----------------------------------------------------------------------------
module if_fetch_stage_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   hold,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic             head_valid_r;
  logic [WIDTH-1:0] head_data_r;

  logic             full_s;
  logic             do_pop_s;
  logic             do_push_s;
  logic [PW-1:0]    rd_next_s;
  logic [CW-1:0]    count_next_s;
  logic [CW-1:0]    remain_s;
  logic             head_valid_next_s;
  logic [WIDTH-1:0] head_data_next_s;

  // Next-state pointers, occupancy and head-register contents.
  always_comb begin
    full_s       = (count_r == CW'(DEPTH));
    do_pop_s     = pop & (count_r != CW'(0));
    do_push_s    = push & (~full_s | do_pop_s);
    rd_next_s    = rd_ptr_r + PW'(do_pop_s);
    count_next_s = count_r + CW'(do_push_s) - CW'(do_pop_s);
    // Entries that were already stored and survive this cycle's pop.
    remain_s     = count_r - CW'(do_pop_s);
    if (remain_s == CW'(0)) begin
      if (do_push_s) begin
        head_valid_next_s = 1'b1;
        head_data_next_s  = push_data;
      end else begin
        head_valid_next_s = 1'b0;
        head_data_next_s  = {WIDTH{1'b0}};
      end
    end else begin
      head_valid_next_s = 1'b1;
      head_data_next_s  = mem_r[rd_next_s];
    end
  end

  // Storage, pointers and the registered head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_valid_r <= 1'b0;
      head_data_r  <= {WIDTH{1'b0}};
    end else if (flush) begin
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      head_valid_r <= 1'b0;
      head_data_r  <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r <= rd_next_s;
      count_r  <= count_next_s;
      // While held, the head may lag the storage; it catches up on release
      // because the next value is always rebuilt from mem_r[rd_ptr].
      if (!hold) begin
        head_valid_r <= head_valid_next_s;
        head_data_r  <= head_data_next_s;
      end
    end
  end

  assign count      = count_r;
  assign full       = full_s;
  assign empty      = (count_r == CW'(0));
  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage: owns the architectural fetch PC, issues in-order
// word fetches over a req/ready channel, buffers returned words in a prefetch
// FIFO and presents {pc, instruction, valid} to the IF/ID register. Handles
// branch redirect (flush + discard of in-flight responses) and hazard freeze.
//
// Ports:
//   clk             clock
//   rst             synchronous reset, active low
//   freeze          hazard stall; holds the presented entry
//   branch_taken    redirect request from EX
//   branch_address  redirect target
//   imem_req        fetch request valid
//   imem_addr       fetch address (word aligned)
//   imem_ready      memory accepts the request this cycle
//   imem_rvalid     response valid (in order, >= 1 cycle after acceptance)
//   imem_rdata      instruction word
//   out_valid       pc/instruction hold a real instruction
//   pc              fetch address + 4 of the presented instruction
//   instruction     presented instruction, zero when out_valid = 0
// -----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter int                    WORD_WIDTH = if_fetch_stage_pkg::WORD_WIDTH,
  parameter int                    FIFO_DEPTH = if_fetch_stage_pkg::FETCH_FIFO_DEPTH,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = WORD_WIDTH'(if_fetch_stage_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_address,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic                  out_valid,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] instruction
);

  import if_fetch_stage_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = 2 * WORD_WIDTH;

  // Architectural state.
  logic [WORD_WIDTH-1:0] fetch_pc_r;     // address presented on imem_addr
  logic [WORD_WIDTH-1:0] redirect_pc_r;  // target parked behind a stale request
  logic [WORD_WIDTH-1:0] resp_pc_r;      // address of the next kept response
  logic [CW-1:0]         outstanding_r;
  logic [CW-1:0]         discard_r;
  logic                  stale_r;
  logic                  pending_r;      // request shown last cycle, not taken

  // FIFO interface.
  logic [CW-1:0] count_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          head_valid_s;
  logic [EW-1:0] head_data_s;
  logic [EW-1:0] push_data_s;

  // Per-cycle decisions.
  logic          deq_s;
  logic          credit_ok_s;
  logic          req_s;
  logic          accept_s;
  logic          rsp_s;
  logic          discard_busy_s;
  logic          push_s;
  logic          unaccepted_s;
  logic [CW-1:0] outstanding_next_s;
  logic [CW-1:0] discard_next_s;

  // Request credit, response routing and counter next-values.
  always_comb begin
    deq_s          = head_valid_s & ~freeze & ~fifo_empty_s;
    credit_ok_s    = fetch_credit_ok(32'(count_s), 32'(outstanding_r),
                                     32'(deq_s), 32'(FIFO_DEPTH));
    // A request left waiting on ready is re-presented unconditionally so the
    // address/valid pair never changes under the memory.
    req_s          = rst & (pending_r | credit_ok_s);
    accept_s       = req_s & imem_ready;
    unaccepted_s   = req_s & ~imem_ready;
    // A response with nothing owed cannot belong to us; ignore it rather than
    // let the counters wrap.
    rsp_s          = imem_rvalid & (outstanding_r != CW'(0));
    discard_busy_s = (discard_r != CW'(0));
    push_s         = rsp_s & ~branch_taken & ~discard_busy_s & (~fifo_full_s | deq_s);
    outstanding_next_s = outstanding_r + CW'(accept_s) - CW'(rsp_s);
    discard_next_s     = discard_r + CW'(accept_s & stale_r)
                         - CW'(rsp_s & discard_busy_s);
    push_data_s    = {resp_pc_r + WORD_WIDTH'(4), imem_rdata};
  end

  // Fetch PC, redirect bookkeeping and request/response counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r    <= RESET_PC;
      redirect_pc_r <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      discard_r     <= {CW{1'b0}};
      stale_r       <= 1'b0;
      pending_r     <= 1'b0;
    end else begin
      outstanding_r <= outstanding_next_s;
      pending_r     <= unaccepted_s;
      if (branch_taken) begin
        // Everything still owed after this edge belongs to the old path.
        discard_r <= outstanding_next_s;
        resp_pc_r <= branch_address;
        if (unaccepted_s) begin
          // The waiting request keeps its address; it is marked so its
          // response is dropped and the target is fetched right after it.
          stale_r       <= 1'b1;
          redirect_pc_r <= branch_address;
        end else begin
          stale_r    <= 1'b0;
          fetch_pc_r <= branch_address;
        end
      end else begin
        discard_r <= discard_next_s;
        if (push_s) begin
          resp_pc_r <= resp_pc_r + WORD_WIDTH'(4);
        end
        if (accept_s) begin
          if (stale_r) begin
            stale_r    <= 1'b0;
            fetch_pc_r <= redirect_pc_r;
          end else begin
            fetch_pc_r <= fetch_pc_r + WORD_WIDTH'(4);
          end
        end
      end
    end
  end

  if_fetch_stage_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_data  (push_data_s),
    .pop        (deq_s),
    .flush      (branch_taken),
    .hold       (freeze),
    .count      (count_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .head_valid (head_valid_s),
    .head_data  (head_data_s)
  );

  assign imem_req    = req_s;
  assign imem_addr   = fetch_pc_r;
  assign out_valid   = head_valid_s;
  assign pc          = head_data_s[EW-1:WORD_WIDTH];
  assign instruction = head_valid_s ? head_data_s[WORD_WIDTH-1:0]
                                    : WORD_WIDTH'(INSTR_NOP);

endmodule
